// File: rtl/hub75_pkg.sv
// Shared constants, drain FSM states and the colour-expansion helper for the
// HUB75 line-capture front end.
package hub75_pkg;

    // Default geometry of the emulated panel.
    localparam int DEF_WIDTH  = 96;
    localparam int DEF_HEIGHT = 48;
    localparam int DEF_AW     = 12;

    // Bit positions inside the 6-bit HUB75 colour bus {b1,g1,r1,b0,g0,r0}.
    localparam int RGB_R0 = 0;
    localparam int RGB_G0 = 1;
    localparam int RGB_B0 = 2;
    localparam int RGB_R1 = 3;
    localparam int RGB_G1 = 4;
    localparam int RGB_B1 = 5;

    // Nibble offsets inside the 24-bit memory word.
    // [23:12] carries the r1/g1/b1 pixel, [11:0] the r0/g0/b0 pixel.
    localparam int WORD_HI_R = 20;
    localparam int WORD_HI_G = 16;
    localparam int WORD_HI_B = 12;
    localparam int WORD_LO_R = 8;
    localparam int WORD_LO_G = 4;
    localparam int WORD_LO_B = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

    // Each 1-bit channel becomes a full-scale or zero 4-bit intensity.
    function automatic logic [23:0] expand_rgb(input logic [5:0] rgb);
        logic [23:0] w;
        w = '0;
        w[WORD_HI_R +: 4] = {4{rgb[RGB_R1]}};
        w[WORD_HI_G +: 4] = {4{rgb[RGB_G1]}};
        w[WORD_HI_B +: 4] = {4{rgb[RGB_B1]}};
        w[WORD_LO_R +: 4] = {4{rgb[RGB_R0]}};
        w[WORD_LO_G +: 4] = {4{rgb[RGB_G0]}};
        w[WORD_LO_B +: 4] = {4{rgb[RGB_B0]}};
        return w;
    endfunction

endpackage

// File: rtl/hub75_sync_edge.sv
// N-bit two-flop synchronizer with a third stage used only to detect rising
// edges of the synchronized signals.
module hub75_sync_edge
    import hub75_pkg::*;
#(
    parameter int N = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] async_i,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;
    logic [N-1:0] s3_q;

    // Synchronizer chain plus edge-history stage.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge is reported while stage 2 is already high and stage 3 still low.
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/hub75_line_capture.sv
// HUB75 receiver: shifts each panel line into one of two ping-pong line banks
// and drains the committed bank into frame memory, one 24-bit word per column.
module hub75_line_capture
    import hub75_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int AW     = DEF_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          hub_sclk,
    input  logic          hub_lat,
    input  logic          hub_oe,
    input  logic [5:0]    hub_rgb,
    input  logic [4:0]    hub_row,
    input  logic          i_clear_err,
    output logic [AW-1:0] o_addr,
    output logic [23:0]   o_data,
    output logic          o_wr_en,
    output logic          o_line_done,
    output logic [4:0]    o_row,
    output logic          o_blank,
    output logic          o_err_overrun,
    output logic          o_err_length
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [COL_W-1:0] WIDTH_C  = COL_W'(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [4:0]       ROWS_C   = 5'(HEIGHT / 2);

    // ---------------------------------------------------------------
    // Input synchronization
    // ---------------------------------------------------------------
    logic [1:0]  edge_rise;
    logic        sclk_rise;
    logic        lat_rise;
    logic [11:0] dsync1_q;
    logic [11:0] dsync2_q;
    logic [5:0]  rgb_s;
    logic [4:0]  row_s;

    hub75_sync_edge #(
        .N(2)
    ) u_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .async_i ({hub_lat, hub_sclk}),
        .rise_o  (edge_rise)
    );

    assign sclk_rise = edge_rise[0];
    assign lat_rise  = edge_rise[1];

    // Two-flop synchronizer for blank/row/colour; stage 2 lines up with the edge detect.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dsync1_q <= '0;
            dsync2_q <= '0;
        end else begin
            dsync1_q <= {hub_oe, hub_row, hub_rgb};
            dsync2_q <= dsync1_q;
        end
    end

    assign rgb_s   = dsync2_q[5:0];
    assign row_s   = dsync2_q[10:6];
    assign o_blank = dsync2_q[11];

    // ---------------------------------------------------------------
    // Shift side: column counter, bank select, line commit, errors
    // ---------------------------------------------------------------
    drain_state_e     state_q, state_d;
    logic [IDX_W-1:0] drain_idx_q, drain_idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] col_after;
    logic [COL_W-1:0] wr_pos;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_bank_q, wr_bank_d;
    logic             drain_bank;
    logic [4:0]       drain_row_q, drain_row_d;
    logic [AW-1:0]    drain_base_q, drain_base_d;
    logic             err_len_q, err_len_d;
    logic             err_over_q, err_over_d;
    logic             shift_ok;
    logic             bank_free;
    logic             start_drain;
    logic             set_len;
    logic             set_over;

    assign shift_ok   = sclk_rise && (col_q != WIDTH_C);
    assign col_after  = col_q + COL_W'(shift_ok);
    assign wr_pos     = COL_W'(WIDTH - 1) - col_q;
    assign wr_idx     = wr_pos[IDX_W-1:0];
    assign drain_bank = ~wr_bank_q;
    // The DONE cycle already releases the drain bank.
    assign bank_free  = (state_q != ST_DRAIN);

    // Latch handling: a shift in the same cycle is counted before the length check.
    always_comb begin
        col_d        = col_after;
        wr_bank_d    = wr_bank_q;
        drain_row_d  = drain_row_q;
        drain_base_d = drain_base_q;
        start_drain  = 1'b0;
        set_len      = 1'b0;
        set_over     = 1'b0;
        if (lat_rise) begin
            col_d = '0;
            if (row_s >= ROWS_C) begin
                set_len = 1'b1;
            end else begin
                if (col_after != WIDTH_C) begin
                    set_len = 1'b1;
                end
                if (bank_free) begin
                    start_drain  = 1'b1;
                    wr_bank_d    = ~wr_bank_q;
                    drain_row_d  = row_s;
                    drain_base_d = AW'(row_s) * AW'(WIDTH);
                end else begin
                    set_over = 1'b1;
                end
            end
        end
        err_len_d  = set_len  ? 1'b1 : (i_clear_err ? 1'b0 : err_len_q);
        err_over_d = set_over ? 1'b1 : (i_clear_err ? 1'b0 : err_over_q);
    end

    // Shift-side state registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_q        <= '0;
            wr_bank_q    <= 1'b0;
            drain_row_q  <= '0;
            drain_base_q <= '0;
            err_len_q    <= 1'b0;
            err_over_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            wr_bank_q    <= wr_bank_d;
            drain_row_q  <= drain_row_d;
            drain_base_q <= drain_base_d;
            err_len_q    <= err_len_d;
            err_over_q   <= err_over_d;
        end
    end

    assign o_err_length  = err_len_q;
    assign o_err_overrun = err_over_q;

    // ---------------------------------------------------------------
    // Ping-pong line banks (contents are not reset)
    // ---------------------------------------------------------------
    logic [5:0] bank_rd [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [5:0] mem [WIDTH];

        // First shifted bit lands in the highest column.
        always_ff @(posedge i_clk) begin
            if (shift_ok && (wr_bank_q == 1'(gi))) begin
                mem[wr_idx] <= rgb_s;
            end
        end

        assign bank_rd[gi] = mem[drain_idx_q];
    end

    // ---------------------------------------------------------------
    // Drain FSM and registered memory-side outputs
    // ---------------------------------------------------------------
    logic          wr_en_q, wr_en_d;
    logic          line_done_q, line_done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [23:0]   data_q, data_d;
    logic [4:0]    row_out_q, row_out_d;

    // Next state and next output values; outputs hold unless written.
    always_comb begin
        state_d     = state_q;
        drain_idx_d = drain_idx_q;
        wr_en_d     = 1'b0;
        line_done_d = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        row_out_d   = row_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start_drain) begin
                    state_d     = ST_DRAIN;
                    drain_idx_d = '0;
                end
            end
            ST_DRAIN: begin
                wr_en_d = 1'b1;
                addr_d  = drain_base_q + AW'(drain_idx_q);
                data_d  = expand_rgb(bank_rd[drain_bank]);
                if (drain_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    drain_idx_d = drain_idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                line_done_d = 1'b1;
                row_out_d   = drain_row_q;
                if (start_drain) begin
                    state_d     = ST_DRAIN;
                    drain_idx_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, drain index and output registers; reset stops writes at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            drain_idx_q <= '0;
            wr_en_q     <= 1'b0;
            line_done_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            row_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            drain_idx_q <= drain_idx_d;
            wr_en_q     <= wr_en_d;
            line_done_q <= line_done_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            row_out_q   <= row_out_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_line_done = line_done_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_row       = row_out_q;

endmodule

// File: tb/tb_hub75_line_capture.sv
// Directed bench for hub75_line_capture with a write/line-done scoreboard.
module tb_hub75_line_capture;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        hub_sclk;
    logic        hub_lat;
    logic        hub_oe;
    logic [5:0]  hub_rgb;
    logic [4:0]  hub_row;
    logic        i_clear_err;
    logic [11:0] o_addr;
    logic [23:0] o_data;
    logic        o_wr_en;
    logic        o_line_done;
    logic [4:0]  o_row;
    logic        o_blank;
    logic        o_err_overrun;
    logic        o_err_length;

    always #5 i_clk = ~i_clk;

    hub75_line_capture dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .hub_sclk      (hub_sclk),
        .hub_lat       (hub_lat),
        .hub_oe        (hub_oe),
        .hub_rgb       (hub_rgb),
        .hub_row       (hub_row),
        .i_clear_err   (i_clear_err),
        .o_addr        (o_addr),
        .o_data        (o_data),
        .o_wr_en       (o_wr_en),
        .o_line_done   (o_line_done),
        .o_row         (o_row),
        .o_blank       (o_blank),
        .o_err_overrun (o_err_overrun),
        .o_err_length  (o_err_length)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [23:0] data;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         wr_seen = 0;
    wr_t        exp_q[$];
    logic [4:0] row_q[$];
    wr_t        mon_e;
    logic [4:0] mon_r;

    // Bench-side model of the two line banks and the sticky flags.
    logic [5:0] m_bank [2][96];
    int         m_fill;
    int         m_col;
    logic       exp_len;
    logic       exp_over;

    function automatic logic [23:0] exp_word(input logic [5:0] v);
        logic [23:0] w;
        w = {{4{v[3]}}, {4{v[4]}}, {4{v[5]}}, {4{v[0]}}, {4{v[1]}}, {4{v[2]}}};
        return w;
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic shift_in(input logic [5:0] v);
        if (m_col < 96) begin
            m_bank[m_fill][95 - m_col] = v;
            m_col++;
        end
        hub_rgb  = v;
        hub_sclk = 1'b0;
        cyc(2);
        hub_sclk = 1'b1;
        cyc(2);
    endtask

    task automatic latch_line(input logic [4:0] row, input bit expect_overrun);
        wr_t e;
        if (m_col != 96 || row >= 5'd24) exp_len = 1'b1;
        if (row < 5'd24) begin
            if (expect_overrun) begin
                exp_over = 1'b1;
            end else begin
                for (int j = 0; j < 96; j++) begin
                    e.addr = 12'(int'(row) * 96 + j);
                    e.data = exp_word(m_bank[m_fill][j]);
                    exp_q.push_back(e);
                end
                row_q.push_back(row);
                m_fill = m_fill ^ 1;
            end
        end
        m_col    = 0;
        hub_sclk = 1'b0;
        hub_row  = row;
        hub_lat  = 1'b1;
        cyc(2);
        hub_lat  = 1'b0;
        cyc(2);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || row_q.size() != 0) && t < 1000) begin
            cyc(1);
            t++;
        end
        check(tag, 36'(t < 1000), 36'(1));
        cyc(3);
    endtask

    task automatic clear_err();
        i_clear_err = 1'b1;
        cyc(1);
        i_clear_err = 1'b0;
        exp_len  = 1'b0;
        exp_over = 1'b0;
        cyc(1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"}, 36'(o_wr_en), 36'(0));
        check({tag, "_line_done"}, 36'(o_line_done), 36'(0));
        check({tag, "_addr"}, 36'(o_addr), 36'(0));
        check({tag, "_data"}, 36'(o_data), 36'(0));
        check({tag, "_row"}, 36'(o_row), 36'(0));
        check({tag, "_errs"}, 36'({o_err_overrun, o_err_length}), 36'(0));
    endtask

    // Scoreboard: every write and line-done pulse is matched against the queues.
    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) begin
            wr_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed addr=%0d data=%h expected no write", o_addr, o_data);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert (o_addr === mon_e.addr) else begin
                    errors++;
                    $error("FAIL wr_addr observed=%0d expected=%0d", o_addr, mon_e.addr);
                end
                checks++;
                assert (o_data === mon_e.data) else begin
                    errors++;
                    $error("FAIL wr_data addr=%0d observed=%h expected=%h", mon_e.addr, o_data, mon_e.data);
                end
            end
        end
        if (o_line_done === 1'b1) begin
            checks++;
            assert (row_q.size() != 0 && exp_q.size() == 0) else begin
                errors++;
                $error("FAIL unexpected_line_done observed row=%0d expected pending=%0d words_left=%0d",
                       o_row, row_q.size(), exp_q.size());
            end
            if (row_q.size() != 0) begin
                mon_r = row_q.pop_front();
                checks++;
                assert (o_row === mon_r) else begin
                    errors++;
                    $error("FAIL line_row observed=%0d expected=%0d", o_row, mon_r);
                end
                $display("line done row=%0d", o_row);
            end
        end
    end

    initial begin
        int t;
        int wr_base;
        i_rst       = 1'b0;
        hub_sclk    = 1'b0;
        hub_lat     = 1'b0;
        hub_oe      = 1'b0;
        hub_rgb     = '0;
        hub_row     = '0;
        i_clear_err = 1'b0;
        m_fill      = 0;
        m_col       = 0;
        exp_len     = 1'b0;
        exp_over    = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < 96; j++)
                m_bank[b][j] = '0;

        // Reset state
        cyc(3);
        check_idle_outputs("reset");
        check("reset_blank", 36'(o_blank), 36'(0));
        i_rst = 1'b1;
        cyc(3);
        check_idle_outputs("post_reset");

        // Blank follows hub_oe
        hub_oe = 1'b1;
        cyc(4);
        check("blank_high", 36'(o_blank), 36'(1));
        hub_oe = 1'b0;
        cyc(4);
        check("blank_low", 36'(o_blank), 36'(0));

        // 1: constant lower pixel white, row 3 -> addr 288..383, data 000FFF
        for (int s = 0; s < 96; s++) shift_in(6'b000111);
        latch_line(5'd3, 1'b0);
        check("t1_first_word", 36'({exp_q[0].addr, exp_q[0].data}), 36'({12'd288, 24'h000FFF}));
        wait_idle("t1_drain_timeout");
        check("t1_err_length", 36'(o_err_length), 36'(exp_len));
        check("t1_row", 36'(o_row), 36'(3));

        // 2: column k carries k%64, row 7
        for (int s = 0; s < 96; s++) shift_in(6'((95 - s) % 64));
        latch_line(5'd7, 1'b0);
        wait_idle("t2_drain_timeout");
        check("t2_err_length", 36'(o_err_length), 36'(0));

        // 3: short line (90 columns) still committed, length error raised then cleared
        for (int s = 0; s < 90; s++) shift_in(6'((s * 5 + 3) % 64));
        latch_line(5'd5, 1'b0);
        cyc(4);
        check("t3_err_length_set", 36'(o_err_length), 36'(1));
        wait_idle("t3_drain_timeout");
        clear_err();
        check("t3_err_length_clr", 36'(o_err_length), 36'(0));

        // 4: second latch 50 cycles after the first while draining -> overrun, dropped
        for (int s = 0; s < 96; s++) shift_in(6'b111000);
        latch_line(5'd9, 1'b0);
        cyc(46);
        latch_line(5'd9, 1'b1);
        cyc(4);
        check("t4_err_overrun", 36'(o_err_overrun), 36'(1));
        wait_idle("t4_drain_timeout");
        cyc(50);
        check("t4_queue_empty", 36'(exp_q.size()), 36'(0));
        check("t4_err_length", 36'(o_err_length), 36'(exp_len));
        clear_err();
        check("t4_errs_clr", 36'({o_err_overrun, o_err_length}), 36'(0));

        // 5: row 24 out of range -> no writes; row 23 -> addr 2208..2303
        wr_base = wr_seen;
        for (int s = 0; s < 96; s++) shift_in(6'b101010);
        latch_line(5'd24, 1'b0);
        cyc(200);
        check("t5_no_writes", 36'(wr_seen - wr_base), 36'(0));
        check("t5_err_length", 36'(o_err_length), 36'(1));
        clear_err();
        for (int s = 0; s < 96; s++) shift_in(6'($urandom_range(0, 63)));
        latch_line(5'd23, 1'b0);
        check("t5_last_addr", 36'(exp_q[95].addr), 36'(2303));
        wait_idle("t5_drain_timeout");
        check("t5_err_length_ok", 36'(o_err_length), 36'(0));

        // 6: reset at drain word 40 -> writes stop at once, no line_done
        for (int s = 0; s < 96; s++) shift_in(6'($urandom_range(0, 63)));
        wr_base = wr_seen;
        latch_line(5'd11, 1'b0);
        t = 0;
        while (wr_seen < wr_base + 40 && t < 1000) begin
            @(negedge i_clk);
            #1;
            t++;
        end
        check("t6_reach_word40", 36'(t < 1000), 36'(1));
        check("t6_wr_en_before", 36'(o_wr_en), 36'(1));
        i_rst = 1'b0;
        #1;
        check("t6_wr_en_async", 36'(o_wr_en), 36'(0));
        check("t6_no_line_done", 36'(o_line_done), 36'(0));
        exp_q.delete();
        row_q.delete();
        m_fill   = 0;
        m_col    = 0;
        exp_len  = 1'b0;
        exp_over = 1'b0;
        cyc(3);
        check_idle_outputs("t6_in_reset");
        i_rst = 1'b1;
        cyc(150);
        check("t6_words_seen", 36'(wr_seen - wr_base), 36'(40));
        for (int s = 0; s < 96; s++) shift_in(6'($urandom_range(0, 63)));
        latch_line(5'd2, 1'b0);
        wait_idle("t6_recover_timeout");

        // 7: 100 shift clocks -> first 96 kept, counter saturates, no length error
        for (int s = 0; s < 100; s++) shift_in(6'($urandom_range(0, 63)));
        latch_line(5'd0, 1'b0);
        wait_idle("t7_drain_timeout");
        check("t7_err_length", 36'(o_err_length), 36'(0));
        check("t7_err_overrun", 36'(o_err_overrun), 36'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
